// File: rtl/hazard_unit.sv
// Hazard detection, EX operand forwarding and drain/halt sequencing for the
// five-stage pipeline, with saturating stall and flush counters.
//
//   state   | meaning
//   RUN     | normal issue
//   WAIT    | data memory miss outstanding, pipeline frozen
//   DRAIN   | halt seen in decode, fetch blocked while older work retires
//   HALTED  | halt retired, pipeline frozen until reset
module hazard_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [REG_AW-1:0] de_rs,
  input  logic [REG_AW-1:0] de_rt,
  input  logic              de_use_rs,
  input  logic              de_use_rt,
  input  logic              de_halt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [DATA_W-1:0] ex_rdat1,
  input  logic [DATA_W-1:0] ex_rdat2,
  input  logic [REG_AW-1:0] ex_wsel,
  input  logic              ex_regWr,
  input  logic              ex_dREN,
  input  logic [REG_AW-1:0] me_wsel,
  input  logic              me_regWr,
  input  logic              me_dREN,
  input  logic              me_dWEN,
  input  logic [DATA_W-1:0] me_ALUOut,
  input  logic              me_br_taken,
  input  logic [REG_AW-1:0] wb_wsel,
  input  logic              wb_regWr,
  input  logic              wb_halt,
  input  logic [DATA_W-1:0] wb_wdat,
  output logic              pc_en,
  output logic              ifde_en,
  output logic              idex_en,
  output logic              exme_en,
  output logic              mewb_en,
  output logic              ifde_flush,
  output logic              idex_flush,
  output logic              exme_flush,
  output logic [1:0]        fwdA_sel,
  output logic [1:0]        fwdB_sel,
  output logic [DATA_W-1:0] fwdA_dat,
  output logic [DATA_W-1:0] fwdB_dat,
  output logic              halt,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic mem_busy, adv, raw, br_flush;
  logic de_dep_ex, de_dep_me, de_dep_wb;

  // Register 0 is hardwired, so it can never carry a dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
    return (dst != '0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (FWD_EN != 0) begin
      if (me_regWr && !me_dREN && reg_match(src, me_wsel))
        sel = 2'b01;
      else if (wb_regWr && reg_match(src, wb_wsel))
        sel = 2'b10;
    end
    return sel;
  endfunction

  assign mem_busy = (me_dREN | me_dWEN) & ~dhit;
  assign adv      = ~mem_busy;

  assign de_dep_ex = (de_use_rs & reg_match(de_rs, ex_wsel)) |
                     (de_use_rt & reg_match(de_rt, ex_wsel));
  assign de_dep_me = (de_use_rs & reg_match(de_rs, me_wsel)) |
                     (de_use_rt & reg_match(de_rt, me_wsel));
  assign de_dep_wb = (de_use_rs & reg_match(de_rs, wb_wsel)) |
                     (de_use_rt & reg_match(de_rt, wb_wsel));

  // With forwarding only a load in EX cannot supply its result in time.
  assign raw = (FWD_EN != 0) ? (ex_regWr & ex_dREN & de_dep_ex)
                             : ((ex_regWr & de_dep_ex) |
                                (me_regWr & de_dep_me) |
                                (wb_regWr & de_dep_wb));

  always_comb begin
    pc_en      = 1'b1;
    ifde_en    = 1'b1;
    idex_en    = 1'b1;
    exme_en    = 1'b1;
    mewb_en    = 1'b1;
    ifde_flush = 1'b0;
    idex_flush = 1'b0;
    exme_flush = 1'b0;
    br_flush   = 1'b0;
    if (state_q == ST_HALTED || mem_busy) begin
      pc_en   = 1'b0;
      ifde_en = 1'b0;
      idex_en = 1'b0;
      exme_en = 1'b0;
      mewb_en = 1'b0;
    end else if (me_br_taken) begin
      ifde_flush = 1'b1;
      idex_flush = 1'b1;
      exme_flush = 1'b1;
      br_flush   = 1'b1;
    end else if (raw || !ihit) begin
      pc_en      = 1'b0;
      ifde_en    = 1'b0;
      idex_flush = 1'b1;
    end
    if (state_q == ST_DRAIN) begin
      pc_en = 1'b0;
      if (ifde_en) ifde_flush = 1'b1;
    end
  end

  assign fwdA_sel = fwd_pick(ex_rs);
  assign fwdB_sel = fwd_pick(ex_rt);

  always_comb begin
    case (fwdA_sel)
      2'b01:   fwdA_dat = me_ALUOut;
      2'b10:   fwdA_dat = wb_wdat;
      default: fwdA_dat = ex_rdat1;
    endcase
    case (fwdB_sel)
      2'b01:   fwdB_dat = me_ALUOut;
      2'b10:   fwdB_dat = wb_wdat;
      default: fwdB_dat = ex_rdat2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (wb_halt)                                state_d = ST_HALTED;
        else if (mem_busy)                          state_d = ST_WAIT;
        else if (de_halt && ifde_en && !me_br_taken) state_d = ST_DRAIN;
      end
      ST_WAIT:  if (dhit) state_d = ST_RUN;
      ST_DRAIN: begin
        if (wb_halt)                state_d = ST_HALTED;
        else if (me_br_taken && adv) state_d = ST_RUN;
      end
      default: state_d = ST_HALTED;
    endcase
    halt_d = (state_d == ST_HALTED);

    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN || state_q == ST_WAIT) && !pc_en && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (br_flush && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard, forwarding and stall controller for the five-stage pipeline: fetch, decode, execute, memory, write_back. It replaces the tied-off forwarding and flush signals in the datapath. It produces per-stage latch enables and flushes, and EX operand forwarding selects and data. It also owns a drain/halt state machine and saturating stall/flush performance counters. A mode parameter selects full forwarding or stall-on-any-RAW.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register index width; register 0 is never a hazard source
- FWD_EN, 1, 1 = forward from EX/MEM and MEM/WB; 0 = stall on any in-flight writer
- CNT_W, 32, performance counter width
- CLK  in  1  clock; all state updates on posedge
- nRST  in  1  asynchronous active-low reset
- ihit, dhit  in  1  cache hits
- de_rs, de_rt  in  REG_AW  decode source registers
- de_use_rs, de_use_rt  in  1  decode instruction reads rs/rt
- de_halt  in  1  decode holds a halt instruction
- ex_rs, ex_rt  in  REG_AW  ID/EX source registers
- ex_rdat1, ex_rdat2  in  DATA_W  ID/EX register-file operands
- ex_wsel  in  REG_AW  ID/EX destination register
- ex_regWr, ex_dREN  in  1  ID/EX destination write and load flags
- me_wsel  in  REG_AW  EX/MEM destination register
- me_regWr, me_dREN, me_dWEN  in  1  EX/MEM control flags
- me_ALUOut  in  DATA_W  EX/MEM ALU result
- me_br_taken  in  1  branch/jump resolved taken in MEM
- wb_wsel  in  REG_AW  MEM/WB destination register
- wb_regWr, wb_halt  in  1  MEM/WB write flag; halt instruction at WB
- wb_wdat  in  DATA_W  write-back data
- pc_en, ifde_en, idex_en, exme_en, mewb_en  out  1  stage latch enables
- ifde_flush, idex_flush, exme_flush  out  1  load a bubble (valid only with matching en)
- fwdA_sel, fwdB_sel  out  2  00 regfile, 01 EX/MEM ALUOut, 10 MEM/WB wdat
- fwdA_dat, fwdB_dat  out  DATA_W  selected EX operands
- halt  out  1  sticky processor halt
- state  out  2  RUN=0, WAIT=1, DRAIN=2, HALTED=3
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation

**Definitions**
- mem_busy = (me_dREN | me_dWEN) & ~dhit
- adv = ~mem_busy
- raw uses only register-0-excluded matches against de_rs/de_rt gated by de_use_*.
  - FWD_EN=1: raw = ex_dREN & ex_regWr matching (load-use only).
  - FWD_EN=0: raw = any matching writer among EX (ex_regWr), MEM (me_regWr) and WB (wb_regWr).

**Priority** (highest first): HALTED, mem_busy, taken branch, raw, ~ihit.
- HALTED: all enables 0, all flushes 0.
- mem_busy: all enables 0.
- me_br_taken & adv:
  - all enables 1.
  - ifde_flush, idex_flush and exme_flush all 1.
  - Overrides raw and ~ihit.
- raw & adv:
  - pc_en=0 and ifde_en=0.
  - idex_en=1 with idex_flush=1.
  - exme_en=1 and mewb_en=1.
- ~ihit & adv: same as raw.
- Otherwise: all enables 1, flushes 0.
- DRAIN adds: pc_en=0 and ifde_flush=1 whenever ifde_en=1.

**Forwarding** (combinational). Operand A uses ex_rs; operand B uses ex_rt.
- FWD_EN=1:
  - Select 01 if me_regWr & ~me_dREN & me_wsel≠0 & me_wsel==src.
  - Else select 10 if wb_regWr & wb_wsel≠0 & wb_wsel==src.
  - Else select 00.
  - EX/MEM wins over MEM/WB.
- FWD_EN=0: selects are always 00.
- fwd*_dat is the mux of ex_rdat*, me_ALUOut and wb_wdat.

**State machine**
- RUN→WAIT on mem_busy; WAIT→RUN when dhit.
- RUN→DRAIN on de_halt & ifde_en & ~me_br_taken.
- DRAIN→RUN on me_br_taken & adv (halt was on a squashed path).
- RUN or DRAIN→HALTED on wb_halt; HALTED is absorbing until reset.
- WAIT→DRAIN priority: from WAIT, the dhit cycle returns to RUN first.

**Outputs and counters**
- halt = (state==HALTED).
- stall_cnt increments each cycle with state∈{RUN,WAIT} and pc_en=0.
- flush_cnt increments on each taken-branch flush cycle.
- Both counters saturate at all-ones.

## Timing
- Enables, flushes and forwarding are combinational, with zero-cycle latency from inputs.
- State, halt and counters are registered and update on posedge CLK.
- Reset (asynchronous, any time): state=RUN, halt=0, stall_cnt=0, flush_cnt=0. Combinational outputs follow inputs immediately.
- A load-use hazard costs exactly 1 stall cycle. The load then forwards from MEM/WB.
- With FWD_EN=0, a dependent instruction waits until the writer leaves WB. That is up to 3 stall cycles.
- A taken branch costs 3 squashed slots and counts 1 in flush_cnt.
- halt asserts the cycle after wb_halt is sampled.

## Test plan
- **ALU RAW, FWD_EN=1:** add r3 followed by sub using r3 -> fwdA_sel=01 and fwdA_dat=me_ALUOut, no stall, stall_cnt stays 0.
- **Load-use:**
  - lw r2 then add r2 -> one cycle with pc_en=0, ifde_en=0, idex_flush=1.
  - Next cycle fwdA_sel=10 and fwdA_dat=wb_wdat; stall_cnt=1.
- **FWD_EN=0 chain:** add r5 then or r5 -> 3 stall cycles, selects stay 00, stall_cnt=3.
- **dmem miss:**
  - me_dREN=1, dhit=0 for 4 cycles -> all enables 0 and state=WAIT.
  - dhit=1 -> enables 1, state=RUN next cycle.
- **Taken branch vs. load-use:** me_br_taken=1 together with raw=1 -> all three flushes 1, pc_en=1, flush_cnt=1.
- **Halt drain:**
  - de_halt -> state=DRAIN, pc_en=0.
  - A taken branch in DRAIN -> RUN.
  - Otherwise wb_halt -> halt=1 next cycle.
  - nRST low mid-DRAIN -> state=0 and counters 0 immediately.
